// File: rtl/alu_pkg.sv
// ============================================================================
// Package : alu_pkg
// Purpose : Shared types for the integer ALU and its HI/LO multiply unit.
//           alu_sel_t    - ALU operation select (C_MFHI/C_MFLO read HI/LO).
//           mult_state_t - control states of the mult_hilo sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // ALU operation select. C_MFHI / C_MFLO route the mult_hilo HI and LO
  // registers onto the ALU result bus.
  typedef enum logic [3:0] {
    C_ADD  = 4'd0,
    C_SUB  = 4'd1,
    C_AND  = 4'd2,
    C_OR   = 4'd3,
    C_XOR  = 4'd4,
    C_NOR  = 4'd5,
    C_SLT  = 4'd6,
    C_SLTU = 4'd7,
    C_SLL  = 4'd8,
    C_SRL  = 4'd9,
    C_SRA  = 4'd10,
    C_LUI  = 4'd11,
    C_MFHI = 4'd12,
    C_MFLO = 4'd13
  } alu_sel_t;

  // Multiply sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } mult_state_t;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/mult_hilo.sv
// ============================================================================
// Module  : mult_hilo
// Purpose : Iterative radix-2 shift-add multiplier feeding the HI/LO register
//           pair (MULT / MULTU). One partial-product step per clock; the
//           2*WIDTH-bit product lands in {hi,lo} WIDTH+1 cycles after start.
// Ports   : clk        rising-edge clock
//           rst        asynchronous active-high reset
//           start      request a multiply of op_a by op_b (ignored while busy)
//           is_signed  1 = two's-complement, 0 = unsigned
//           op_a, op_b operands, sampled with start
//           busy       high while a multiply is in progress
//           done       one-cycle pulse when hi/lo take a new product
//           hi, lo     registered HI/LO contents
//           hilo_wr, hi_in, lo_in
//                      direct HI/LO write port, present only when the macro
//                      HILO_WRITE_EN is defined
// Config  : `define HILO_WRITE_EN to build the direct-write port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_hilo
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef HILO_WRITE_EN
  input  logic             hilo_wr,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Counter must be able to hold WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  mult_state_t        state, state_next;
  logic               accept;

  logic [WIDTH-1:0]   mcand;     // multiplicand magnitude
  logic [WIDTH-1:0]   mplier;    // multiplier magnitude, shifted right per step
  logic               neg;       // product must be negated on write-back
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;

  // --------------------------------------------------------------------------
  // Operand conditioning. Magnitudes are kept WIDTH-bit unsigned so the most
  // negative operand (e.g. 0x80 at WIDTH=8) maps to its true magnitude.
  // --------------------------------------------------------------------------
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg = is_signed & op_a[WIDTH-1];
    b_neg = is_signed & op_b[WIDTH-1];
    a_mag = a_neg ? (~op_a + {{(WIDTH-1){1'b0}}, 1'b1}) : op_a;
    b_mag = b_neg ? (~op_b + {{(WIDTH-1){1'b0}}, 1'b1}) : op_b;
  end

  // --------------------------------------------------------------------------
  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  // The adder carry becomes the new MSB, so nothing is lost after WIDTH steps.
  // --------------------------------------------------------------------------
  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] product;

  always_comb begin
    partial  = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_step = {partial, acc[WIDTH-1:1]};
    product  = neg ? (~acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;
  end

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // This step takes the counter from 1 to 0.
        if (count == CW'(1)) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state == RUN) || (state == FINISH);

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      count  <= '0;
    end else if (accept) begin
      mcand  <= a_mag;
      mplier <= b_mag;
      neg    <= a_neg ^ b_neg;
      acc    <= '0;
      count  <= CW'(WIDTH);
    end else if (state == RUN) begin
      acc    <= acc_step;
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      count  <= count - CW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // HI/LO registers and completion pulse. done is registered so it is
  // coincident with the new hi/lo values rather than one cycle ahead.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == FINISH);
      if (state == FINISH) begin
        hi <= product[2*WIDTH-1:WIDTH];
        lo <= product[WIDTH-1:0];
      end
`ifdef HILO_WRITE_EN
      // Direct write only in IDLE; a simultaneous start takes precedence.
      else if ((state == IDLE) && hilo_wr && !start) begin
        hi <= hi_in;
        lo <= lo_in;
      end
`endif
    end
  end

endmodule : mult_hilo

`default_nettype wire
